// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and fault classification for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, MEM, CAPT, RESP} state_t;
    typedef enum logic [1:0] {C_OK, C_MISALIGN, C_RANGE, C_ILLEGAL} cause_t;

    // Access context kept from accept until the load result is extracted.
    typedef struct packed {
        logic       we;
        logic [2:0] funct3;
        logic [1:0] off;
    } acc_t;

    // Priority: illegal funct3 > misaligned > out of range.
    function automatic cause_t fault_cause(input logic        we,
                                           input logic [2:0]  funct3,
                                           input logic [31:0] addr,
                                           input int unsigned depth);
        logic illegal;
        logic misalign;
        illegal  = we ? (funct3 > F3_W) : ((funct3 == 3'b011) || (funct3[2:1] == 2'b11));
        misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        if (illegal)                       return C_ILLEGAL;
        else if (misalign)                 return C_MISALIGN;
        else if (addr[31:2] >= 30'(depth)) return C_RANGE;
        else                               return C_OK;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Request/response handshake plus data-memory port of the load/store unit.
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_cause;
    logic        mem_we;
    logic [3:0]  mem_byteEnable;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_cause,
               mem_we, mem_byteEnable, mem_a, mem_wd
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_cause,
               mem_we, mem_byteEnable, mem_a, mem_wd
    );
endinterface

// File: rtl/lsu_align.sv
// Store lane replication / byte enables and load byte-lane extract with extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_st_funct3,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_wdata,
    output logic [3:0]  o_st_be_c,
    output logic [31:0] o_st_wd_c,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_ld_rd,
    output logic [31:0] o_ld_data_c
);

    logic [31:0] w_shifted;

    always_comb begin
        o_st_be_c = 4'b0000;
        o_st_wd_c = 32'h0;
        case (i_st_funct3)
            F3_B: begin
                o_st_be_c = 4'b0001 << i_st_off;
                o_st_wd_c = {4{i_st_wdata[7:0]}};
            end
            F3_H: begin
                o_st_be_c = 4'b0011 << i_st_off;
                o_st_wd_c = {2{i_st_wdata[15:0]}};
            end
            F3_W: begin
                o_st_be_c = 4'b1111;
                o_st_wd_c = i_st_wdata;
            end
            default: ;
        endcase
    end

    assign w_shifted = i_ld_rd >> {i_ld_off, 3'b000};

    always_comb begin
        o_ld_data_c = 32'h0;
        case (i_ld_funct3)
            F3_B:    o_ld_data_c = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    o_ld_data_c = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_W:    o_ld_data_c = w_shifted;
            F3_BU:   o_ld_data_c = {24'h0, w_shifted[7:0]};
            F3_HU:   o_ld_data_c = {16'h0, w_shifted[15:0]};
            default: o_ld_data_c = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit in front of a registered-read data memory; one request in flight.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic       clk,
    input  logic       reset,
    lsu_ctrl_if.slave  bus
);

    state_t      r_state, w_state_nxt;
    acc_t        r_acc, w_acc_nxt;
    logic        r_resp_valid, w_resp_valid_nxt;
    logic [31:0] r_resp_rdata, w_resp_rdata_nxt;
    cause_t      r_resp_cause, w_resp_cause_nxt;
    logic        r_mem_we, w_mem_we_nxt;
    logic [3:0]  r_mem_be, w_mem_be_nxt;
    logic [31:0] r_mem_a, w_mem_a_nxt;
    logic [31:0] r_mem_wd, w_mem_wd_nxt;

    logic        w_accept;
    cause_t      w_fault;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_wd;
    logic [31:0] w_ld_data;

    assign bus.req_ready      = (r_state == IDLE) && !reset;
    assign bus.resp_valid     = r_resp_valid;
    assign bus.resp_rdata     = r_resp_rdata;
    assign bus.resp_cause     = r_resp_cause;
    assign bus.mem_we         = r_mem_we;
    assign bus.mem_byteEnable = r_mem_be;
    assign bus.mem_a          = r_mem_a;
    assign bus.mem_wd         = r_mem_wd;

    assign w_accept = bus.req_valid && bus.req_ready;
    assign w_fault  = fault_cause(bus.req_we, bus.req_funct3, bus.req_addr, DEPTH_WORDS);

    // Store path sees the live request; load path sees the captured context.
    lsu_align u_align (
        .i_st_funct3 (bus.req_funct3),
        .i_st_off    (bus.req_addr[1:0]),
        .i_st_wdata  (bus.req_wdata),
        .o_st_be_c   (w_st_be),
        .o_st_wd_c   (w_st_wd),
        .i_ld_funct3 (r_acc.funct3),
        .i_ld_off    (r_acc.off),
        .i_ld_rd     (bus.mem_rd),
        .o_ld_data_c (w_ld_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_acc        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_cause <= C_OK;
            r_mem_we     <= 1'b0;
            r_mem_be     <= 4'b0000;
            r_mem_a      <= 32'h0;
            r_mem_wd     <= 32'h0;
        end else begin
            r_state      <= w_state_nxt;
            r_acc        <= w_acc_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_resp_cause <= w_resp_cause_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_be     <= w_mem_be_nxt;
            r_mem_a      <= w_mem_a_nxt;
            r_mem_wd     <= w_mem_wd_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = (w_fault == C_OK) ? MEM : RESP;
            MEM:     w_state_nxt = CAPT;
            CAPT:    w_state_nxt = RESP;
            RESP:    if (bus.resp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Memory strobes are only ever set on the edge entering MEM, so they last one cycle.
    always_comb begin
        w_acc_nxt        = r_acc;
        w_resp_valid_nxt = r_resp_valid;
        w_resp_rdata_nxt = r_resp_rdata;
        w_resp_cause_nxt = r_resp_cause;
        w_mem_we_nxt     = 1'b0;
        w_mem_be_nxt     = 4'b0000;
        w_mem_a_nxt      = 32'h0;
        w_mem_wd_nxt     = 32'h0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_acc_nxt = '{we: bus.req_we, funct3: bus.req_funct3, off: bus.req_addr[1:0]};
                    if (w_fault != C_OK) begin
                        w_resp_valid_nxt = 1'b1;
                        w_resp_rdata_nxt = 32'h0;
                        w_resp_cause_nxt = w_fault;
                    end else begin
                        w_mem_we_nxt = 1'b1;
                        w_mem_a_nxt  = {bus.req_addr[31:2], 2'b00};
                        w_mem_be_nxt = bus.req_we ? w_st_be : 4'b0000;
                        w_mem_wd_nxt = bus.req_we ? w_st_wd : 32'h0;
                    end
                end
            end
            CAPT: begin
                w_resp_valid_nxt = 1'b1;
                w_resp_rdata_nxt = r_acc.we ? 32'h0 : w_ld_data;
                w_resp_cause_nxt = C_OK;
            end
            RESP: begin
                if (bus.resp_ready) w_resp_valid_nxt = 1'b0;
            end
            default: ;
        endcase
    end

endmodule
